// File: rtl/sprite_mixer_pkg.sv
// Shared definitions for the sprite mixer: state encoding, colour width,
// default sprite count and small arithmetic helpers.
package sprite_mixer_pkg;

    localparam int RGB_W            = 3;
    localparam int NSPRITES_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BLANK = 2'd2
    } mix_state_e;

    function automatic logic [7:0] frame_inc(input logic [7:0] value);
        return value + 8'd1;
    endfunction

endpackage

// File: rtl/sprite_mixer_priority_select.sv
// Combinational fixed-priority colour select: the lowest-index qualified
// sprite supplies the pixel colour.
module sprite_priority_select
    import sprite_mixer_pkg::*;
#(
    parameter int NSPRITES = NSPRITES_DEFAULT
) (
    input  logic [NSPRITES-1:0]       hit,
    input  logic [RGB_W*NSPRITES-1:0] sprite_color,
    output logic                      any_hit,
    output logic [RGB_W-1:0]          sel_color
);

    // Walk from the highest index down so the lowest set hit overwrites last.
    always_comb begin
        any_hit   = |hit;
        sel_color = {RGB_W{1'b0}};
        for (int i = NSPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_color = sprite_color[RGB_W*i +: RGB_W];
            end else begin
                sel_color = sel_color;
            end
        end
    end

endmodule

// File: rtl/sprite_mixer.sv
// Final-pixel compositor: merges sprite and playfield layers by fixed
// priority and publishes per-frame collision snapshots at vsync.
module sprite_mixer
    import sprite_mixer_pkg::*;
#(
    parameter int NSPRITES = NSPRITES_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vsync,
    input  logic                      display_on,
    input  logic [NSPRITES-1:0]       sprite_gfx,
    input  logic [NSPRITES-1:0]       sprite_active,
    input  logic                      playfield_gfx,
    input  logic [RGB_W*NSPRITES-1:0] sprite_color,
    input  logic [RGB_W-1:0]          pf_color,
    input  logic [RGB_W-1:0]          bg_color,
    input  logic                      coll_ack,
    output logic [RGB_W-1:0]          rgb,
    output logic [NSPRITES-1:0]       spr_spr_coll,
    output logic [NSPRITES-1:0]       spr_pf_coll,
    output logic                      coll_pending,
    output logic                      coll_overrun,
    output logic [7:0]                frame_count
);

    localparam logic [NSPRITES-1:0] ONE_HOT0 = {{(NSPRITES-1){1'b0}}, 1'b1};

    mix_state_e          state_r;
    mix_state_e          state_nxt_s;
    logic                vsync_q_r;
    logic                rise_s;
    logic                commit_s;
    logic                accum_en_s;
    logic [NSPRITES-1:0] hit_s;
    logic [NSPRITES-1:0] ss_s;
    logic [NSPRITES-1:0] sp_s;
    logic [NSPRITES-1:0] ss_acc_r;
    logic [NSPRITES-1:0] sp_acc_r;
    logic                any_hit_s;
    logic [RGB_W-1:0]    sel_color_s;
    logic [RGB_W-1:0]    pix_s;

    assign hit_s  = sprite_gfx & sprite_active;
    assign rise_s = vsync & ~vsync_q_r;

    sprite_priority_select #(
        .NSPRITES (NSPRITES)
    ) u_prio (
        .hit          (hit_s),
        .sprite_color (sprite_color),
        .any_hit      (any_hit_s),
        .sel_color    (sel_color_s)
    );

    // Per-pixel collision terms, suppressed outside the visible area.
    always_comb begin
        ss_s = {NSPRITES{1'b0}};
        sp_s = {NSPRITES{1'b0}};
        for (int i = 0; i < NSPRITES; i++) begin
            ss_s[i] = display_on & hit_s[i] & (|(hit_s & ~(ONE_HOT0 << i)));
            sp_s[i] = display_on & hit_s[i] & playfield_gfx;
        end
    end

    // Pixel colour priority: blanking, then sprites, then playfield, then background.
    always_comb begin
        pix_s = {RGB_W{1'b0}};
        if (!display_on) begin
            pix_s = {RGB_W{1'b0}};
        end else if (any_hit_s) begin
            pix_s = sel_color_s;
        end else if (playfield_gfx) begin
            pix_s = pf_color;
        end else begin
            pix_s = bg_color;
        end
    end

    // Frame FSM next state; IDLE discards the partial frame seen after reset.
    always_comb begin
        state_nxt_s = state_r;
        commit_s    = 1'b0;
        accum_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_nxt_s = ST_BLANK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                accum_en_s = 1'b1;
                if (rise_s) begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_BLANK;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_BLANK: begin
                if (!vsync) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_BLANK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and vsync edge-detect delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            vsync_q_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            vsync_q_r <= vsync;
        end
    end

    // Collision accumulators; a commit restarts them at zero for the new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_acc_r <= {NSPRITES{1'b0}};
            sp_acc_r <= {NSPRITES{1'b0}};
        end else if (commit_s) begin
            ss_acc_r <= {NSPRITES{1'b0}};
            sp_acc_r <= {NSPRITES{1'b0}};
        end else if (accum_en_s) begin
            ss_acc_r <= ss_acc_r | ss_s;
            sp_acc_r <= sp_acc_r | sp_s;
        end
    end

    // Snapshot and handshake; a commit outranks an ack arriving on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spr_spr_coll <= {NSPRITES{1'b0}};
            spr_pf_coll  <= {NSPRITES{1'b0}};
            coll_pending <= 1'b0;
            coll_overrun <= 1'b0;
            frame_count  <= 8'd0;
        end else if (commit_s) begin
            spr_spr_coll <= ss_acc_r | ss_s;
            spr_pf_coll  <= sp_acc_r | sp_s;
            coll_pending <= 1'b1;
            coll_overrun <= coll_overrun | coll_pending;
            frame_count  <= frame_inc(frame_count);
        end else if (coll_ack) begin
            coll_pending <= 1'b0;
            coll_overrun <= 1'b0;
        end
    end

    // Registered pixel output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb <= {RGB_W{1'b0}};
        end else begin
            rgb <= pix_s;
        end
    end

endmodule

// File: tb/tb_sprite_mixer.sv
// Directed plus randomized bench for sprite_mixer, checked every cycle
// against a frame-level behavioural model.
module tb_sprite_mixer;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           vsync;
    logic           display_on;
    logic [N-1:0]   sprite_gfx;
    logic [N-1:0]   sprite_active;
    logic           playfield_gfx;
    logic [3*N-1:0] sprite_color;
    logic [2:0]     pf_color;
    logic [2:0]     bg_color;
    logic           coll_ack;
    logic [2:0]     rgb;
    logic [N-1:0]   spr_spr_coll;
    logic [N-1:0]   spr_pf_coll;
    logic           coll_pending;
    logic           coll_overrun;
    logic [7:0]     frame_count;

    int checks = 0;
    int errors = 0;

    // model state
    logic [2:0]   m_rgb;
    logic [N-1:0] m_ss_acc, m_sp_acc, m_ssc, m_spc;
    logic         m_pend, m_ovr;
    logic [7:0]   m_fc;
    logic         m_vq, m_synced, m_counting;
    logic [7:0]   fc_saved;

    sprite_mixer #(.NSPRITES(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .vsync         (vsync),
        .display_on    (display_on),
        .sprite_gfx    (sprite_gfx),
        .sprite_active (sprite_active),
        .playfield_gfx (playfield_gfx),
        .sprite_color  (sprite_color),
        .pf_color      (pf_color),
        .bg_color      (bg_color),
        .coll_ack      (coll_ack),
        .rgb           (rgb),
        .spr_spr_coll  (spr_spr_coll),
        .spr_pf_coll   (spr_pf_coll),
        .coll_pending  (coll_pending),
        .coll_overrun  (coll_overrun),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rgb = 3'd0; m_ss_acc = '0; m_sp_acc = '0; m_ssc = '0; m_spc = '0;
        m_pend = 1'b0; m_ovr = 1'b0; m_fc = 8'd0;
        m_vq = 1'b0; m_synced = 1'b0; m_counting = 1'b0;
    endtask

    // One clock edge of the reference behaviour, from the inputs held across it.
    task automatic model_update();
        logic [N-1:0] hits, ss, sp;
        int k;
        bit rise;
        if (reset) begin
            model_reset();
        end else begin
            hits = sprite_gfx & sprite_active;
            for (int i = 0; i < N; i++) begin
                ss[i] = display_on && hits[i] && ($countones(hits) > 1);
                sp[i] = display_on && hits[i] && playfield_gfx;
            end
            if (!display_on) m_rgb = 3'd0;
            else if (hits != '0) begin
                k = 0;
                while (!hits[k]) k++;
                m_rgb = sprite_color[3*k +: 3];
            end
            else if (playfield_gfx) m_rgb = pf_color;
            else m_rgb = bg_color;

            rise = vsync && !m_vq;
            if (m_counting && rise) begin
                m_ssc = m_ss_acc | ss;
                m_spc = m_sp_acc | sp;
                m_ss_acc = '0;
                m_sp_acc = '0;
                m_fc = m_fc + 8'd1;
                m_ovr = m_ovr | m_pend;
                m_pend = 1'b1;
            end else begin
                if (m_counting) begin
                    m_ss_acc = m_ss_acc | ss;
                    m_sp_acc = m_sp_acc | sp;
                end
                if (coll_ack) begin
                    m_pend = 1'b0;
                    m_ovr = 1'b0;
                end
            end
            if (rise) begin
                m_counting = 1'b0;
                m_synced = 1'b1;
            end else if (m_synced && !m_counting && !vsync) begin
                m_counting = 1'b1;
            end
            m_vq = vsync;
        end
    endtask

    task automatic check_all();
        chk("rgb", 32'(rgb), 32'(m_rgb));
        chk("spr_spr_coll", 32'(spr_spr_coll), 32'(m_ssc));
        chk("spr_pf_coll", 32'(spr_pf_coll), 32'(m_spc));
        chk("coll_pending", 32'(coll_pending), 32'(m_pend));
        chk("coll_overrun", 32'(coll_overrun), 32'(m_ovr));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic rnd_pix();
        display_on    = ($urandom_range(0, 7) != 0);
        sprite_gfx    = 4'($urandom);
        sprite_active = 4'($urandom);
        playfield_gfx = 1'($urandom);
        sprite_color  = 12'($urandom);
        pf_color      = 3'($urandom);
        bg_color      = 3'($urandom);
    endtask

    task automatic quiet_pix();
        sprite_gfx = '0; sprite_active = '0; playfield_gfx = 1'b0;
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b0; display_on = 1'b0; coll_ack = 1'b0;
        sprite_gfx = '0; sprite_active = '0; playfield_gfx = 1'b0;
        sprite_color = 12'h000; pf_color = 3'b101; bg_color = 3'b010;
        model_reset();
        step();
        step();
        chk("reset_rgb", 32'(rgb), 32'd0);
        chk("reset_fc", 32'(frame_count), 32'd0);
        reset = 1'b0;
        step();

        // priority
        display_on = 1'b1; sprite_active = 4'b1111; sprite_gfx = 4'b0110;
        sprite_color = {3'b111, 3'b110, 3'b011, 3'b001}; playfield_gfx = 1'b1;
        step();
        chk("prio_sprite1", 32'(rgb), 32'b011);
        sprite_gfx = 4'b0000;
        step();
        chk("prio_pf", 32'(rgb), 32'b101);
        display_on = 1'b0; sprite_gfx = 4'b0001;
        step();
        chk("prio_blank", 32'(rgb), 32'd0);

        // first rise after reset is discarded
        display_on = 1'b1; quiet_pix(); sprite_active = 4'b1111;
        vsync = 1'b1; step();
        vsync = 1'b0; step();
        chk("first_fc", 32'(frame_count), 32'd0);
        chk("first_pend", 32'(coll_pending), 32'd0);
        sprite_gfx = 4'b0101;
        repeat (3) step();
        sprite_gfx = 4'b1000; playfield_gfx = 1'b1; step();
        sprite_gfx = 4'b0000; playfield_gfx = 1'b0; step();
        vsync = 1'b1; step();
        chk("commit_ss", 32'(spr_spr_coll), 32'b0101);
        chk("commit_sp", 32'(spr_pf_coll), 32'b1000);
        chk("commit_fc", 32'(frame_count), 32'd1);
        chk("commit_pend", 32'(coll_pending), 32'd1);
        vsync = 1'b0; step();

        // overrun, ack, ack coinciding with commit
        sprite_gfx = 4'b0110; step();
        sprite_gfx = 4'b0000; step();
        vsync = 1'b1; step();
        chk("overrun_set", 32'(coll_overrun), 32'd1);
        vsync = 1'b0; coll_ack = 1'b1; step();
        coll_ack = 1'b0;
        chk("ack_pend", 32'(coll_pending), 32'd0);
        chk("ack_ovr", 32'(coll_overrun), 32'd0);
        chk("ack_snap", 32'(spr_spr_coll), 32'b0110);
        step();
        vsync = 1'b1; coll_ack = 1'b1; step();
        chk("ack_commit_pend", 32'(coll_pending), 32'd1);
        chk("ack_commit_ovr", 32'(coll_overrun), 32'd0);
        vsync = 1'b0; coll_ack = 1'b0; step();

        // gating: inactive sprites and blanked overlaps do not count
        sprite_gfx = 4'b1111; sprite_active = 4'b0000; playfield_gfx = 1'b1; step();
        chk("gate_inactive_rgb", 32'(rgb), 32'b101);
        display_on = 1'b0; sprite_gfx = 4'b0011; sprite_active = 4'b1111; step();
        display_on = 1'b1; quiet_pix(); sprite_active = 4'b1111;
        vsync = 1'b1; step();
        chk("gate_ss", 32'(spr_spr_coll), 32'd0);
        chk("gate_sp", 32'(spr_pf_coll), 32'd0);
        vsync = 1'b0; step();

        // overlap exactly on the rise cycle, then a clean frame
        sprite_gfx = 4'b1001; vsync = 1'b1; step();
        chk("rise_overlap", 32'(spr_spr_coll), 32'b1001);
        sprite_gfx = 4'b0000; vsync = 1'b0; step();
        step();
        vsync = 1'b1; step();
        chk("new_frame_clean", 32'(spr_spr_coll), 32'd0);
        vsync = 1'b0; step();

        // randomized frames
        repeat (30) begin
            repeat ($urandom_range(3, 12)) begin
                rnd_pix(); vsync = 1'b0; coll_ack = ($urandom_range(0, 3) == 0);
                step();
            end
            repeat ($urandom_range(1, 2)) begin
                rnd_pix(); vsync = 1'b1; coll_ack = ($urandom_range(0, 3) == 0);
                step();
            end
        end
        coll_ack = 1'b0;

        // frame_count wrap after 256 commits
        quiet_pix(); vsync = 1'b0; step();
        fc_saved = m_fc;
        repeat (256) begin
            vsync = 1'b1; step();
            vsync = 1'b0; step();
        end
        chk("fc_wrap", 32'(frame_count), 32'(fc_saved));

        // reset mid-frame
        rnd_pix(); display_on = 1'b1; step();
        reset = 1'b1;
        #1;
        model_reset();
        chk("midreset_rgb", 32'(rgb), 32'd0);
        chk("midreset_ss", 32'(spr_spr_coll), 32'd0);
        chk("midreset_pend", 32'(coll_pending), 32'd0);
        chk("midreset_fc", 32'(frame_count), 32'd0);
        step();
        reset = 1'b0; vsync = 1'b0; step();
        sprite_gfx = 4'b0011; sprite_active = 4'b1111; step();
        vsync = 1'b1; step();
        chk("post_reset_discard_pend", 32'(coll_pending), 32'd0);
        chk("post_reset_discard_fc", 32'(frame_count), 32'd0);
        vsync = 1'b0; step();
        step();
        vsync = 1'b1; step();
        chk("post_reset_commit_fc", 32'(frame_count), 32'd1);
        chk("post_reset_commit_ss", 32'(spr_spr_coll), 32'b0011);
        vsync = 1'b0; step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
